// File: rtl/env_gen_pkg.sv
// env_gen_pkg: shared types for the polyphonic ADSR envelope generator.
//   stage_e : 3-bit stage code driven on the STAGE output of each voice.
package env_gen_pkg;

  localparam int STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } stage_e;

endpackage

// File: rtl/env_voice.sv
// env_voice: one ADSR envelope voice.
//   clk, rst_n      : system clock, async active-low reset
//   locked          : enable; low freezes every register in the voice
//   tick            : shared rate tick from the prescaler
//   gate            : note gate for this voice
//   attack/decay/rel_rate : ticks per step minus one, sampled live
//   sustain         : live sustain level
//   env, stage, active : registered level, stage code, stage != IDLE
module env_voice
  import env_gen_pkg::*;
#(
  parameter int ENV_W  = 8,
  parameter int RATE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              locked,
  input  logic              tick,
  input  logic              gate,
  input  logic [RATE_W-1:0] attack,
  input  logic [RATE_W-1:0] decay,
  input  logic [RATE_W-1:0] rel_rate,
  input  logic [ENV_W-1:0]  sustain,
  output logic [ENV_W-1:0]  env,
  output logic [2:0]        stage,
  output logic              active
);

  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  stage_e            st;
  logic [RATE_W-1:0] cnt;
  logic [RATE_W-1:0] rate;
  logic              gate_q;
  logic              rise;
  logic              fall;
  logic              step;
  logic              gated_stage;
  logic              retrig_stage;

  // Rate of whichever stage is running; rates are not latched at entry.
  always_comb begin
    rate = '0;
    case (st)
      ST_ATTACK:  rate = attack;
      ST_DECAY:   rate = decay;
      ST_RELEASE: rate = rel_rate;
      default:    rate = '0;
    endcase
  end

  assign rise         = gate & ~gate_q;
  assign fall         = ~gate & gate_q;
  assign step         = tick && (cnt == rate);
  assign gated_stage  = (st == ST_ATTACK) || (st == ST_DECAY) || (st == ST_SUSTAIN);
  assign retrig_stage = (st == ST_IDLE) || (st == ST_RELEASE);
  assign stage        = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= ST_IDLE;
      env    <= '0;
      cnt    <= '0;
      gate_q <= 1'b0;
      active <= 1'b0;
    end else if (locked) begin
      gate_q <= gate;
      if (fall && gated_stage) begin
        // A fall at level 0 (e.g. sustain of 0) has nothing to release.
        st     <= (env == '0) ? ST_IDLE : ST_RELEASE;
        active <= (env != '0);
        cnt    <= '0;
      end else if (rise && retrig_stage) begin
        // Retrigger keeps the current level so there is no click.
        st     <= ST_ATTACK;
        active <= 1'b1;
        cnt    <= '0;
      end else begin
        case (st)
          ST_ATTACK: begin
            if (env == ENV_MAX) begin
              st  <= ST_DECAY;
              cnt <= '0;
            end else if (step) begin
              env <= env + 1'b1;
              cnt <= '0;
            end else if (tick) begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_DECAY: begin
            if (env <= sustain) begin
              st  <= ST_SUSTAIN;
              env <= sustain;
              cnt <= '0;
            end else if (step) begin
              env <= env - 1'b1;
              cnt <= '0;
            end else if (tick) begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_SUSTAIN: env <= sustain;
          ST_RELEASE: begin
            if (env == '0) begin
              st     <= ST_IDLE;
              active <= 1'b0;
              cnt    <= '0;
            end else if (step) begin
              env <= env - 1'b1;
              cnt <= '0;
            end else if (tick) begin
              cnt <= cnt + 1'b1;
            end
          end
          default: env <= '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/env_gen_poly.sv
// env_gen_poly: N_VOICES ADSR envelopes sharing one set of controls and
// one rate prescaler.
//   CLK, RST_N  : system clock, async active-low reset
//   LOCKED      : clock-valid enable; low freezes prescaler and all voices
//   GATE        : per-voice note gate
//   ATTACK, DECAY, RELEASE : ticks per step minus one
//   SUSTAIN     : sustain level
//   ENV         : packed levels, voice v at [v*ENV_W +: ENV_W]
//   STAGE       : packed 3-bit stage codes, voice v at [v*3 +: 3]
//   ACTIVE      : per-voice stage != IDLE
module env_gen_poly
  import env_gen_pkg::*;
#(
  parameter int N_VOICES = 4,
  parameter int ENV_W    = 8,
  parameter int RATE_W   = 16,
  parameter int PRESCALE = 16
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        LOCKED,
  input  logic [N_VOICES-1:0]         GATE,
  input  logic [RATE_W-1:0]           ATTACK,
  input  logic [RATE_W-1:0]           DECAY,
  input  logic [ENV_W-1:0]            SUSTAIN,
  input  logic [RATE_W-1:0]           RELEASE,
  output logic [N_VOICES*ENV_W-1:0]   ENV,
  output logic [N_VOICES*STAGE_W-1:0] STAGE,
  output logic [N_VOICES-1:0]         ACTIVE
);

  // PRESCALE of 1 still needs a 1-bit counter; it simply never leaves 0.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;
  logic          tick;

  logic [N_VOICES-1:0][ENV_W-1:0]   env_l;
  logic [N_VOICES-1:0][STAGE_W-1:0] stage_l;

  assign tick = LOCKED && (pcnt == P_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      pcnt <= '0;
    else if (LOCKED) pcnt <= (pcnt == P_LAST) ? '0 : pcnt + 1'b1;
  end

  for (genvar v = 0; v < N_VOICES; v++) begin : g_voice
    env_voice #(
      .ENV_W  (ENV_W),
      .RATE_W (RATE_W)
    ) u_voice (
      .clk      (CLK),
      .rst_n    (RST_N),
      .locked   (LOCKED),
      .tick     (tick),
      .gate     (GATE[v]),
      .attack   (ATTACK),
      .decay    (DECAY),
      .rel_rate (RELEASE),
      .sustain  (SUSTAIN),
      .env      (env_l[v]),
      .stage    (stage_l[v]),
      .active   (ACTIVE[v])
    );
  end

  assign ENV   = env_l;
  assign STAGE = stage_l;

endmodule

// File: tb/tb_env_gen_poly.sv
module tb_env_gen_poly;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        LOCKED = 1'b1;
  logic [3:0]  GATE = '0;
  logic [15:0] atk = '0, dcy = '0, rel = '0;
  logic [7:0]  sus = 8'd128;
  logic [31:0] env_o, env4;
  logic [11:0] stage_o, stage4;
  logic [3:0]  act_o, act4;

  int checks = 0;
  int errors = 0;

  env_gen_poly #(.N_VOICES(4), .ENV_W(8), .RATE_W(16), .PRESCALE(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .LOCKED(LOCKED), .GATE(GATE),
    .ATTACK(atk), .DECAY(dcy), .SUSTAIN(sus), .RELEASE(rel),
    .ENV(env_o), .STAGE(stage_o), .ACTIVE(act_o));

  env_gen_poly #(.N_VOICES(4), .ENV_W(8), .RATE_W(16), .PRESCALE(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .LOCKED(LOCKED), .GATE(GATE),
    .ATTACK(atk), .DECAY(dcy), .SUSTAIN(sus), .RELEASE(rel),
    .ENV(env4), .STAGE(stage4), .ACTIVE(act4));

  always #5 CLK = ~CLK;

  // Reference model of the PRESCALE=1 instance, straight from the stage rules.
  localparam int P1 = 1;
  int m_env[4], m_st[4], m_cnt[4], m_gq[4];
  int m_pc;
  int r;
  bit tk, g, rs, fl, stp;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_pc = 0;
      for (int v = 0; v < 4; v++) begin
        m_env[v] = 0; m_st[v] = 0; m_cnt[v] = 0; m_gq[v] = 0;
      end
    end else if (LOCKED) begin
      tk = (m_pc == P1 - 1);
      m_pc = tk ? 0 : m_pc + 1;
      for (int v = 0; v < 4; v++) begin
        g  = GATE[v];
        rs = g && !m_gq[v];
        fl = !g && m_gq[v];
        m_gq[v] = g;
        r = (m_st[v] == 1) ? int'(atk) : (m_st[v] == 2) ? int'(dcy) :
            (m_st[v] == 4) ? int'(rel) : 0;
        stp = tk && (m_cnt[v] == r);
        if (fl && m_st[v] >= 1 && m_st[v] <= 3) begin
          m_st[v] = (m_env[v] == 0) ? 0 : 4; m_cnt[v] = 0;
        end else if (rs && (m_st[v] == 0 || m_st[v] == 4)) begin
          m_st[v] = 1; m_cnt[v] = 0;
        end else begin
          case (m_st[v])
            1: if (m_env[v] == 255) begin m_st[v] = 2; m_cnt[v] = 0; end
               else if (stp) begin m_env[v]++; m_cnt[v] = 0; end
               else if (tk) m_cnt[v] = (m_cnt[v] + 1) % 65536;
            2: if (m_env[v] <= int'(sus)) begin m_st[v] = 3; m_env[v] = int'(sus); m_cnt[v] = 0; end
               else if (stp) begin m_env[v]--; m_cnt[v] = 0; end
               else if (tk) m_cnt[v] = (m_cnt[v] + 1) % 65536;
            3: m_env[v] = int'(sus);
            4: if (m_env[v] == 0) begin m_st[v] = 0; m_cnt[v] = 0; end
               else if (stp) begin m_env[v]--; m_cnt[v] = 0; end
               else if (tk) m_cnt[v] = (m_cnt[v] + 1) % 65536;
            default: m_env[v] = 0;
          endcase
        end
      end
    end
  end

  function automatic logic [47:0] exp_all();
    logic [31:0] e; logic [11:0] s; logic [3:0] a;
    for (int v = 0; v < 4; v++) begin
      e[v*8 +: 8] = 8'(m_env[v]);
      s[v*3 +: 3] = 3'(m_st[v]);
      a[v]        = (m_st[v] != 0);
    end
    return {e, s, a};
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; GATE = '0; LOCKED = 1'b1;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; GATE = '0; atk = 0; dcy = 0; rel = 0; sus = 8'd128;
    repeat (3) @(negedge CLK);
    checks++;
    if ({env_o, stage_o, act_o} !== 48'd0) begin
      errors++; $display("FAIL reset_hold got %h want 0", {env_o, stage_o, act_o});
    end
    RST_N = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge CLK);
      checks++;
      if ({env_o, stage_o, act_o} !== 48'd0) begin
        errors++; $display("FAIL idle_c%0d got %h want 0", c, {env_o, stage_o, act_o});
      end
    end
  endtask

  task automatic test_full_adsr();
    logic [7:0] we; logic [2:0] ws; bit chk;
    @(negedge CLK); GATE = 4'b0001;
    for (int c = 0; c <= 384; c++) begin
      @(negedge CLK);
      checks++;
      if ({env_o, stage_o, act_o} !== exp_all()) begin
        errors++; $display("FAIL adsr_model c%0d got %h want %h", c, {env_o, stage_o, act_o}, exp_all());
      end
      chk = 1'b1;
      case (c)
        0:   begin we = 0;   ws = 1; end
        255: begin we = 255; ws = 1; end
        256: begin we = 255; ws = 2; end
        383: begin we = 128; ws = 2; end
        384: begin we = 128; ws = 3; end
        default: chk = 1'b0;
      endcase
      if (chk) begin
        checks++;
        if ({env_o[7:0], stage_o[2:0], env_o[31:8]} !== {we, ws, 24'd0}) begin
          errors++; $display("FAIL adsr_pt c%0d got env=%0d stage=%0d others=%h want env=%0d stage=%0d",
                             c, env_o[7:0], stage_o[2:0], env_o[31:8], we, ws);
        end
      end
    end
    GATE = 4'b0000;
    for (int c = 0; c <= 129; c++) begin
      @(negedge CLK);
      checks++;
      if ({env_o, stage_o, act_o} !== exp_all()) begin
        errors++; $display("FAIL rel_model c%0d got %h want %h", c, {env_o, stage_o, act_o}, exp_all());
      end
      if (c == 0 || c == 128 || c == 129) begin
        we = (c == 0) ? 8'd128 : 8'd0;
        ws = (c == 129) ? 3'd0 : 3'd4;
        checks++;
        if ({env_o[7:0], stage_o[2:0], act_o[0]} !== {we, ws, (c != 129)}) begin
          errors++; $display("FAIL rel_pt c%0d got env=%0d stage=%0d act=%b want env=%0d stage=%0d",
                             c, env_o[7:0], stage_o[2:0], act_o[0], we, ws);
        end
      end
    end
  endtask

  task automatic test_rate();
    int n; int times[4]; logic [7:0] prev;
    do_reset(); atk = 16'd2; GATE = 4'b0001; n = 0; prev = env4[7:0];
    for (int t = 0; t < 200 && n < 4; t++) begin
      @(negedge CLK);
      if (env4[7:0] !== prev) begin times[n] = t; n++; prev = env4[7:0]; end
    end
    checks++;
    if (n < 4) begin
      errors++; $display("FAIL rate_steps got %0d steps want 4", n);
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (times[i] - times[i-1] !== 12) begin
          errors++; $display("FAIL rate_spacing%0d got %0d want 12", i, times[i] - times[i-1]);
        end
      end
      checks++;
      if (env4[7:0] !== 8'd4) begin
        errors++; $display("FAIL rate_level got %0d want 4", env4[7:0]);
      end
    end
    atk = 16'd0;
  endtask

  task automatic test_retrigger();
    int w;
    do_reset(); sus = 8'd128; GATE = 4'b0001;
    w = 0;
    while (stage_o[2:0] !== 3'd3 && w < 500) begin @(negedge CLK); w++; end
    GATE = 4'b0000;
    while (env_o[7:0] !== 8'd60 && w < 800) begin @(negedge CLK); w++; end
    checks++;
    if (w >= 800) begin
      errors++; $display("FAIL retrig_wait got timeout want env 60");
    end
    GATE = 4'b0001;
    @(negedge CLK);
    checks++;
    if ({env_o[7:0], stage_o[2:0]} !== {8'd60, 3'd1}) begin
      errors++; $display("FAIL retrig_hold got env=%0d stage=%0d want env=60 stage=1", env_o[7:0], stage_o[2:0]);
    end
    @(negedge CLK);
    checks++;
    if ({env_o[7:0], stage_o[2:0]} !== {8'd61, 3'd1}) begin
      errors++; $display("FAIL retrig_step got env=%0d stage=%0d want env=61 stage=1", env_o[7:0], stage_o[2:0]);
    end
  endtask

  task automatic test_live_sustain();
    int w;
    do_reset(); sus = 8'd128; GATE = 4'b0001;
    w = 0;
    while (stage_o[2:0] !== 3'd3 && w < 500) begin @(negedge CLK); w++; end
    checks++;
    if (env_o[7:0] !== 8'd128) begin
      errors++; $display("FAIL sus_level got %0d want 128", env_o[7:0]);
    end
    sus = 8'd200;
    @(negedge CLK);
    checks++;
    if ({env_o[7:0], stage_o[2:0]} !== {8'd200, 3'd3}) begin
      errors++; $display("FAIL sus_live got env=%0d stage=%0d want env=200 stage=3", env_o[7:0], stage_o[2:0]);
    end
    do_reset(); sus = 8'd128;
    GATE = 4'b0001;
    repeat (256) @(negedge CLK);
    checks++;
    if ({env_o[7:0], stage_o[2:0]} !== {8'd255, 3'd1}) begin
      errors++; $display("FAIL peak got env=%0d stage=%0d want env=255 stage=1", env_o[7:0], stage_o[2:0]);
    end
    GATE = 4'b0000;
    @(negedge CLK);
    checks++;
    if ({env_o[7:0], stage_o[2:0]} !== {8'd255, 3'd4}) begin
      errors++; $display("FAIL fall_at_peak got env=%0d stage=%0d want env=255 stage=4", env_o[7:0], stage_o[2:0]);
    end
    @(negedge CLK);
    checks++;
    if (env_o[7:0] !== 8'd254) begin
      errors++; $display("FAIL fall_peak_step got %0d want 254", env_o[7:0]);
    end
  endtask

  task automatic test_sustain_zero();
    int w;
    do_reset(); sus = 8'd0; GATE = 4'b0010;
    w = 0;
    while (stage_o[5:3] !== 3'd3 && w < 800) begin @(negedge CLK); w++; end
    repeat (5) @(negedge CLK);
    checks++;
    if ({env_o[15:8], stage_o[5:3], act_o[1]} !== {8'd0, 3'd3, 1'b1}) begin
      errors++; $display("FAIL sus0_hold got env=%0d stage=%0d act=%b want 0 3 1", env_o[15:8], stage_o[5:3], act_o[1]);
    end
    GATE = 4'b0000;
    @(negedge CLK);
    checks++;
    if ({stage_o[5:3], act_o[1]} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL sus0_fall got stage=%0d act=%b want 0 0", stage_o[5:3], act_o[1]);
    end
    sus = 8'd128;
  endtask

  task automatic test_freeze();
    logic [47:0] snap;
    do_reset(); atk = 16'd1; GATE = 4'b0001;
    repeat (100) @(negedge CLK);
    LOCKED = 1'b0;
    @(negedge CLK);
    snap = {env_o, stage_o, act_o};
    for (int c = 0; c < 50; c++) begin
      if (c == 20) GATE = 4'b0010;
      @(negedge CLK);
      checks++;
      if ({env_o, stage_o, act_o} !== snap) begin
        errors++; $display("FAIL freeze_c%0d got %h want %h", c, {env_o, stage_o, act_o}, snap);
      end
    end
    LOCKED = 1'b1;
    @(negedge CLK);
    checks++;
    if ({stage_o[5:3], stage_o[2:0]} !== {3'd1, 3'd4}) begin
      errors++; $display("FAIL freeze_edges got v1=%0d v0=%0d want v1=1 v0=4", stage_o[5:3], stage_o[2:0]);
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      checks++;
      if ({env_o, stage_o, act_o} !== exp_all()) begin
        errors++; $display("FAIL resume_c%0d got %h want %h", c, {env_o, stage_o, act_o}, exp_all());
      end
    end
    atk = 16'd0;
  endtask

  task automatic test_async_reset();
    int w;
    do_reset(); dcy = 16'd3; sus = 8'd0; GATE = 4'b0001;
    w = 0;
    while (stage_o[2:0] !== 3'd2 && w < 500) begin @(negedge CLK); w++; end
    repeat (10) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({env_o, stage_o, act_o} !== 48'd0) begin
      errors++; $display("FAIL async_rst got %h want 0", {env_o, stage_o, act_o});
    end
    @(negedge CLK);
    GATE = 4'b0000; RST_N = 1'b1; dcy = 16'd0; sus = 8'd128;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      checks++;
      if ({env_o, stage_o, act_o} !== exp_all()) begin
        errors++; $display("FAIL rand_c%0d got %h want %h", c, {env_o, stage_o, act_o}, exp_all());
      end
      for (int v = 0; v < 4; v++)
        if ($urandom_range(0, 15) == 0) GATE[v] = ~GATE[v];
      LOCKED = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0)
        sus = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 1) * 255) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 199) == 0) begin
        atk = 16'($urandom_range(0, 3)); dcy = 16'($urandom_range(0, 3)); rel = 16'($urandom_range(0, 3));
      end
    end
    LOCKED = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_adsr();
    test_rate();
    test_retrigger();
    test_live_sustain();
    test_sustain_zero();
    test_freeze();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
